// File: rtl/memory_access_unit_if.sv
// -----------------------------------------------------------------------------
// memory_access_unit_if
// Data-memory request/acknowledge bus between the memory stage and the data
// memory.
//   dmem_req   : access request, held until dmem_ack
//   dmem_we    : 1 = write, 0 = read (valid while dmem_req)
//   dmem_addr  : byte address (valid while dmem_req)
//   dmem_wdata : store data (valid while dmem_req && dmem_we)
//   dmem_ack   : memory completes the access this cycle
//   dmem_rdata : load data, valid with dmem_ack on reads
//   dmem_err   : access fault, valid with dmem_ack
// master = memory stage, slave = data memory.
// -----------------------------------------------------------------------------
interface memory_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        dmem_err;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata, dmem_err
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata, dmem_err
    );
endinterface

// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit
// Memory stage of the 5-stage Y86-64 pipeline. Decodes the M-register fields,
// performs the data-memory access over a req/ack bus and loads the M->W
// writeback register. While an access is outstanding mem_stall holds the
// upstream pipeline and bubbles are written into W.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   M_stat/icode/valE/valA/dstE/dstM : fields of the E->M register
//   dmem (master)       : data-memory request/ack bus
//   mem_stall           : combinational freeze request for F/D/E and M
//   W_stat/icode/valE/valM/dstE/dstM : M->W register outputs
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYCLES busy cycles without dmem_ack (reported as stat ADR).
// -----------------------------------------------------------------------------
module memory_access_unit #(
`ifdef MEM_TIMEOUT_EN
    parameter int          TIMEOUT_CYCLES = 16,
`endif
    parameter logic [63:0] ADDR_LIMIT     = 64'd8192
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            M_stat,
    input  logic [3:0]            M_icode,
    input  logic [63:0]           M_valE,
    input  logic [63:0]           M_valA,
    input  logic [3:0]            M_dstE,
    input  logic [3:0]            M_dstM,
    memory_access_unit_if.master  dmem,
    output logic                  mem_stall,
    output logic [2:0]            W_stat,
    output logic [3:0]            W_icode,
    output logic [63:0]           W_valE,
    output logic [63:0]           W_valM,
    output logic [3:0]            W_dstE,
    output logic [3:0]            W_dstM
);
    localparam logic [2:0]  STAT_AOK = 3'd1;
    localparam logic [2:0]  STAT_ADR = 3'd3;
    localparam logic [3:0]  REG_NONE = 4'hF;
    localparam logic [63:0] ADDR_MAX = ADDR_LIMIT - 64'd8;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } wreg_t;

    // Reset value and bubble are identical: a nop with no destinations.
    localparam wreg_t W_BUBBLE = '{STAT_AOK, 4'h1, 64'd0, 64'd0, REG_NONE, REG_NONE};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q;
    wreg_t       w_q;
    logic        req_q, we_q;
    logic [63:0] addr_q, wdata_q;

    // Op decode
    logic        is_rd, is_wr, in_range, mem_op;
    logic [63:0] addr_sel;
    wreg_t       m_pass;

    assign is_rd    = (M_icode == 4'h5) || (M_icode == 4'h9) || (M_icode == 4'hB);
    assign is_wr    = (M_icode == 4'h4) || (M_icode == 4'hA) || (M_icode == 4'h8);
    // ret/popq address the stack through valA; everything else uses valE.
    assign addr_sel = ((M_icode == 4'h9) || (M_icode == 4'hB)) ? M_valA : M_valE;
    // Unsigned compare also rejects wrap-around addresses near 2^64.
    assign in_range = (addr_sel <= ADDR_MAX);
    assign mem_op   = (is_rd || is_wr) && (M_stat == STAT_AOK) && in_range;
    assign m_pass   = '{M_stat, M_icode, M_valE, 64'd0, M_dstE, M_dstM};

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 5) ? 5 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q;
    logic          timeout;
    // Fires on the TIMEOUT_CYCLES-th busy cycle without an ack; ack wins.
    assign timeout = (state_q == BUSY) && !dmem.dmem_ack && (cnt_q == CNT_LAST);
`else
    logic          timeout;
    assign timeout = 1'b0;
`endif

    assign mem_stall = ((state_q == IDLE) && mem_op) ||
                       ((state_q == BUSY) && !dmem.dmem_ack && !timeout);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            w_q     <= W_BUBBLE;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        req_q   <= 1'b1;
                        we_q    <= is_wr;
                        addr_q  <= addr_sel;
                        wdata_q <= M_valA;
                        w_q     <= W_BUBBLE;
                        state_q <= BUSY;
`ifdef MEM_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else begin
                        w_q <= m_pass;
                        // Legal-status memory op outside the data memory.
                        if ((is_rd || is_wr) && (M_stat == STAT_AOK))
                            w_q.stat <= STAT_ADR;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack) begin
                        req_q   <= 1'b0;
                        w_q     <= m_pass;
                        w_q.valM <= we_q ? 64'd0 : dmem.dmem_rdata;
                        if (dmem.dmem_err) begin
                            w_q.stat <= STAT_ADR;
                            w_q.dstM <= REG_NONE;
                        end
                        state_q <= IDLE;
                    end else if (timeout) begin
                        req_q    <= 1'b0;
                        w_q      <= m_pass;
                        w_q.stat <= STAT_ADR;
                        w_q.dstM <= REG_NONE;
                        state_q  <= IDLE;
                    end else begin
                        w_q <= W_BUBBLE;
`ifdef MEM_TIMEOUT_EN
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign W_stat  = w_q.stat;
    assign W_icode = w_q.icode;
    assign W_valE  = w_q.valE;
    assign W_valM  = w_q.valM;
    assign W_dstE  = w_q.dstE;
    assign W_dstM  = w_q.dstM;
endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed scenarios plus a
// randomized instruction stream checked against a transaction-level model.
module tb_memory_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;
    logic        mem_stall;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;

    int checks = 0;
    int errors = 0;

    memory_access_unit_if bus();

    memory_access_unit dut (
        .clk(clk), .reset(reset),
        .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .dmem(bus.master),
        .mem_stall(mem_stall),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                           input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
        M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
    endtask

    // Issues one instruction and follows it to completion, checking every
    // cycle against what the instruction's semantics require.
    task automatic do_op(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                         input int wait_cyc, input logic [63:0] rdata, input logic err,
                         output int stalls);
        logic rd, wr, inr, mop;
        logic [63:0] a;
        logic [2:0] est;
        rd  = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr  = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
        a   = ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
        inr = a <= 64'd8184;
        mop = (rd || wr) && (st == 3'd1) && inr;
        stalls = 0;
        drive_m(st, ic, ve, va, de, dm);
        bus.dmem_ack = 1'b0;
        #1;
        checks++;
        if (mem_stall !== mop) begin
            errors++; $display("FAIL issue_stall ic=%h got %b want %b", ic, mem_stall, mop);
        end
        if (mem_stall) stalls++;
        step();
        if (!mop) begin
            est = ((rd || wr) && st == 3'd1) ? 3'd3 : st;
            checks++;
            if ({W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, bus.dmem_req} !==
                {est, ic, ve, 64'd0, de, dm, 1'b0}) begin
                errors++;
                $display("FAIL passthru ic=%h got stat=%0d ic=%h vE=%h vM=%h dE=%h dM=%h req=%b want stat=%0d vE=%h dE=%h dM=%h",
                         ic, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, bus.dmem_req, est, ve, de, dm);
            end
            return;
        end
        for (int k = 0; k <= wait_cyc; k++) begin
            checks++;
            if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr} !== {1'b1, wr, a} ||
                (wr && bus.dmem_wdata !== va)) begin
                errors++;
                $display("FAIL request ic=%h got req=%b we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                         ic, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, wr, a, va);
            end
            checks++;
            if ({W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM} !==
                {3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF}) begin
                errors++;
                $display("FAIL bubble got stat=%0d ic=%h dE=%h dM=%h", W_stat, W_icode, W_dstE, W_dstM);
            end
            if (k == wait_cyc) break;
            checks++;
            if (mem_stall !== 1'b1) begin
                errors++; $display("FAIL busy_stall got %b want 1", mem_stall);
            end
            if (mem_stall) stalls++;
            step();
        end
        bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata; bus.dmem_err = err;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++; $display("FAIL ack_stall got %b want 0", mem_stall);
        end
        step();
        bus.dmem_ack = 1'b0; bus.dmem_err = 1'b0;
        checks++;
        if ({bus.dmem_req, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM} !==
            {1'b0, err ? 3'd3 : st, ic, ve, rd ? rdata : 64'd0, de, err ? 4'hF : dm}) begin
            errors++;
            $display("FAIL complete ic=%h got req=%b stat=%0d vE=%h vM=%h dE=%h dM=%h want vM=%h err=%b",
                     ic, bus.dmem_req, W_stat, W_valE, W_valM, W_dstE, W_dstM, rd ? rdata : 64'd0, err);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        drive_m(3'd1, 4'h5, 64'h100, 64'h0, 4'hF, 4'h2);
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'd0; bus.dmem_err = 1'b0;
        step(); step();
        checks++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, W_stat, W_icode, W_valE,
             W_valM, W_dstE, W_dstM} !== {2'b00, 128'd0, 3'd1, 4'd1, 128'd0, 8'hFF}) begin
            errors++;
            $display("FAIL reset_state got req=%b we=%b addr=%h stat=%0d ic=%h dE=%h dM=%h",
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, W_stat, W_icode, W_dstE, W_dstM);
        end
        reset = 1'b0;
        drive_m(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        step();
        n = 0;
    endtask

    task automatic test_passthrough();
        int s;
        do_op(3'd1, 4'h6, 64'h2A, 64'h0, 4'd3, 4'hF, 0, 64'd0, 1'b0, s);
        checks++;
        if ({W_icode, W_valE, W_dstE, bus.dmem_req} !== {4'h6, 64'h2A, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL opq got ic=%h vE=%h dE=%h req=%b want 6 2a 3 0", W_icode, W_valE, W_dstE, bus.dmem_req);
        end
    endtask

    task automatic test_load();
        int s;
        do_op(3'd1, 4'h5, 64'h100, 64'h0, 4'hF, 4'd2, 3, 64'hDEAD, 1'b0, s);
        checks++;
        if (s != 4 || W_valM !== 64'hDEAD || W_dstM !== 4'd2) begin
            errors++;
            $display("FAIL mrmovq got stalls=%0d vM=%h dM=%h want 4 dead 2", s, W_valM, W_dstM);
        end
    endtask

    task automatic test_push();
        int s;
        do_op(3'd1, 4'hA, 64'h1F8, 64'h55, 4'd4, 4'hF, 1, 64'h0, 1'b0, s);
        checks++;
        if (W_icode !== 4'hA || W_valE !== 64'h1F8 || W_valM !== 64'd0) begin
            errors++;
            $display("FAIL pushq got ic=%h vE=%h vM=%h want a 1f8 0", W_icode, W_valE, W_valM);
        end
    endtask

    task automatic test_boundary();
        int s;
        do_op(3'd1, 4'h4, 64'd8190, 64'h1, 4'hF, 4'hF, 0, 64'd0, 1'b0, s);
        checks++;
        if (W_stat !== 3'd3 || s != 0) begin
            errors++; $display("FAIL rmmovq_8190 got stat=%0d stalls=%0d want 3 0", W_stat, s);
        end
        do_op(3'd1, 4'h4, 64'd8184, 64'h7, 4'hF, 4'hF, 0, 64'd0, 1'b0, s);
        checks++;
        if (W_stat !== 3'd1 || s != 1) begin
            errors++; $display("FAIL rmmovq_8184 got stat=%0d stalls=%0d want 1 1", W_stat, s);
        end
        do_op(3'd1, 4'h5, 64'd8185, 64'h0, 4'hF, 4'd1, 0, 64'd0, 1'b0, s);
        do_op(3'd1, 4'hB, 64'h0, 64'hFFFF_FFFF_FFFF_FFF9, 4'd4, 4'd1, 0, 64'd0, 1'b0, s);
        checks++;
        if (W_stat !== 3'd3) begin
            errors++; $display("FAIL wrap_addr got stat=%0d want 3", W_stat);
        end
        do_op(3'd2, 4'h5, 64'h10, 64'h0, 4'hF, 4'd1, 0, 64'd0, 1'b0, s);
        do_op(3'd1, 4'h5, 64'h40, 64'h0, 4'hF, 4'd1, 0, 64'hBEEF, 1'b1, s);
        checks++;
        if (W_stat !== 3'd3 || W_dstM !== 4'hF) begin
            errors++; $display("FAIL read_err got stat=%0d dM=%h want 3 f", W_stat, W_dstM);
        end
    endtask

    task automatic test_reset_busy();
        drive_m(3'd1, 4'h5, 64'h200, 64'h0, 4'hF, 4'd3);
        bus.dmem_ack = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({bus.dmem_req, W_stat, W_icode, W_valM, W_dstE, W_dstM} !== {1'b0, 3'd1, 4'd1, 64'd0, 8'hFF}) begin
            errors++;
            $display("FAIL reset_busy got req=%b stat=%0d ic=%h dM=%h", bus.dmem_req, W_stat, W_icode, W_dstM);
        end
        drive_m(3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'h1234;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++; $display("FAIL late_ack_stall got %b want 0", mem_stall);
        end
        step();
        bus.dmem_ack = 1'b0;
        checks++;
        if (bus.dmem_req !== 1'b0 || W_valM !== 64'd0 || W_icode !== 4'h1) begin
            errors++; $display("FAIL late_ack got req=%b vM=%h ic=%h", bus.dmem_req, W_valM, W_icode);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ic;
        logic [2:0]  st;
        logic [63:0] ve, va;
        int s, r;
        for (int i = 0; i < 60; i++) begin
            ic = 4'($urandom_range(0, 11));
            r  = $urandom_range(0, 9);
            st = (r == 0) ? 3'd2 : (r == 1) ? 3'd4 : 3'd1;
            ve = {$urandom, $urandom};
            va = {$urandom, $urandom};
            r  = $urandom_range(0, 9);
            if (r < 7) begin
                ve = 64'($urandom_range(0, 1023)) << 3;
                va = 64'($urandom_range(0, 1023)) << 3;
            end else if (r == 7) begin
                ve = 64'd8184 + 64'($urandom_range(0, 16));
                va = 64'd8184 + 64'($urandom_range(0, 16));
            end
            do_op(st, ic, ve, va, 4'($urandom), 4'($urandom), $urandom_range(0, 3),
                  {$urandom, $urandom}, ($urandom_range(0, 7) == 0), s);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        drive_m(3'd1, 4'h5, 64'h300, 64'h0, 4'hF, 4'd6);
        bus.dmem_ack = 1'b0;
        step();
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            if (mem_stall !== 1'b1 || bus.dmem_req !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL timeout_stall got bad=%0d stall=%b want 0 0", bad, mem_stall);
        end
        step();
        checks++;
        if ({bus.dmem_req, W_stat, W_icode, W_valM, W_dstM} !== {1'b0, 3'd3, 4'h5, 64'd0, 4'hF}) begin
            errors++;
            $display("FAIL timeout got req=%b stat=%0d ic=%h vM=%h dM=%h", bus.dmem_req, W_stat, W_icode, W_valM, W_dstM);
        end
        drive_m(3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_push();
        test_boundary();
        test_reset_busy();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
